// File: rtl/emmc_req_arb.sv
// emmc_req_arb
//   Round-robin arbiter that shares a single emmc_sm byte port among NREQ
//   requesters. One transaction is in flight at a time. The block issues it to
//   emmc_sm, waits for emmc_sm to finish (ready drops, then returns), and then
//   pulses done_o to the requester that owns the transaction. A watchdog aborts
//   a transaction that takes too long and reports it as an error.
//
// Handshake with emmc_sm:
//   - A command is accepted on any clock edge where sm_start_o=1 and sm_ready_i=1.
//   - The command completes on the first edge after the accept where sm_ready_i
//     is high again, provided it was seen low in between.
//   - Requesters hold req_i[k] high until done_o[k]. A request that drops before
//     it wins arbitration is never granted.
//
// Ports
//   clk_i, arst_i        core clock; asynchronous active-high reset
//   req_i/we_i/dat_i     per-requester request, direction (1=write), write byte
//   gnt_o                one-hot grant, held from win until the done cycle
//   done_o/err_o         one-cycle completion pulse; error flag, valid with done_o
//   dat_o                last byte read; holds until the next read capture
//   busy_o               high whenever the FSM is outside IDLE
//   sm_start_o/sm_we_o/sm_dat_o   command to emmc_sm
//   sm_dat_i/sm_dvalid_i/sm_ready_i  response from emmc_sm
//   state_o              current FSM state, for debug and checkers
//                        (0=IDLE 1=ISSUE 2=BUSY 3=DONE 4=DRAIN)
module emmc_req_arb #(
  parameter int NREQ      = 2,
  parameter int DAT_WIDTH = 8,
  parameter int TIMEOUT   = 4096
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic [NREQ-1:0]           req_i,
  input  logic [NREQ-1:0]           we_i,
  input  logic [NREQ*DAT_WIDTH-1:0] dat_i,
  output logic [NREQ-1:0]           gnt_o,
  output logic [NREQ-1:0]           done_o,
  output logic                      err_o,
  output logic [DAT_WIDTH-1:0]      dat_o,
  output logic                      busy_o,
  output logic                      sm_start_o,
  output logic                      sm_we_o,
  output logic [DAT_WIDTH-1:0]      sm_dat_o,
  input  logic [DAT_WIDTH-1:0]      sm_dat_i,
  input  logic                      sm_dvalid_i,
  input  logic                      sm_ready_i,
  output logic [2:0]                state_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Only meaningful when TIMEOUT != 0; the watchdog is disabled otherwise.
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_BUSY  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t          state;
  logic [PW-1:0]   idx;
  logic [PW-1:0]   ptr;
  logic [TW-1:0]   timer;
  logic            seen_low;
  logic            got_data;

  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic            wd_hit;
  logic [TW-1:0]   timer_inc;

  assign state_o = state;

  // Index arithmetic modulo NREQ (NREQ need not be a power of two).
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Round-robin pick: scan from the farthest offset down so the request
  // closest to ptr (offset 0 first) is the one left in pick_idx.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[wrap_add(ptr, i)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_add(ptr, i);
      end
    end
  end

  assign wd_hit    = (TIMEOUT != 0) && (timer == TMAX);
  assign timer_inc = (timer == '1) ? timer : timer + 1'b1;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state      <= S_IDLE;
      idx        <= '0;
      ptr        <= '0;
      timer      <= '0;
      seen_low   <= 1'b0;
      got_data   <= 1'b0;
      gnt_o      <= '0;
      done_o     <= '0;
      err_o      <= 1'b0;
      dat_o      <= '0;
      busy_o     <= 1'b0;
      sm_start_o <= 1'b0;
      sm_we_o    <= 1'b0;
      sm_dat_o   <= '0;
    end else begin
      // done_o/err_o are single-cycle pulses.
      done_o <= '0;
      err_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sm_ready_i && pick_found) begin
            idx             <= pick_idx;
            gnt_o           <= '0;
            gnt_o[pick_idx] <= 1'b1;
            sm_we_o         <= we_i[pick_idx];
            sm_dat_o        <= dat_i[pick_idx*DAT_WIDTH +: DAT_WIDTH];
            sm_start_o      <= 1'b1;
            timer           <= '0;
            busy_o          <= 1'b1;
            state           <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // sm_start_o is always high here, so ready alone means accepted.
          if (sm_ready_i) begin
            sm_start_o <= 1'b0;
            timer      <= '0;
            state      <= S_BUSY;
          end else if (wd_hit) begin
            done_o     <= gnt_o;
            err_o      <= 1'b1;
            gnt_o      <= '0;
            sm_start_o <= 1'b0;
            ptr        <= wrap_add(idx, 1);
            seen_low   <= 1'b0;
            got_data   <= 1'b0;
            state      <= S_DRAIN;
          end else begin
            timer <= timer_inc;
          end
        end
        S_BUSY: begin
          if (!sm_ready_i) seen_low <= 1'b1;
          if (!sm_we_o && sm_dvalid_i) begin
            dat_o    <= sm_dat_i;
            got_data <= 1'b1;
          end
          if (seen_low && sm_ready_i) begin
            done_o <= gnt_o;
            // A dvalid arriving on the completion cycle still counts.
            err_o  <= !sm_we_o && !(got_data || sm_dvalid_i);
            state  <= S_DONE;
          end else if (wd_hit) begin
            done_o     <= gnt_o;
            err_o      <= 1'b1;
            gnt_o      <= '0;
            sm_start_o <= 1'b0;
            ptr        <= wrap_add(idx, 1);
            seen_low   <= 1'b0;
            got_data   <= 1'b0;
            state      <= S_DRAIN;
          end else begin
            timer <= timer_inc;
          end
        end
        S_DONE: begin
          gnt_o    <= '0;
          ptr      <= wrap_add(idx, 1);
          seen_low <= 1'b0;
          got_data <= 1'b0;
          busy_o   <= 1'b0;
          state    <= S_IDLE;
        end
        S_DRAIN: begin
          // Wait for emmc_sm to come back before arbitrating again.
          if (sm_ready_i) begin
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_emmc_req_arb.sv
`timescale 1ns/1ps
module tb_emmc_req_arb;

  localparam int NREQ = 2;
  localparam int DW   = 8;
  localparam int TO   = 16;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic arst_i;
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  logic [NREQ-1:0]    req_i, we_i, gnt_o, done_o;
  logic [NREQ*DW-1:0] dat_i;
  logic               err_o, busy_o, sm_start_o, sm_we_o;
  logic [DW-1:0]      dat_o, sm_dat_o, sm_dat_i;
  logic               sm_dvalid_i, sm_ready_i;
  logic [2:0]         state_o;

  emmc_req_arb #(.NREQ(NREQ), .DAT_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .req_i(req_i), .we_i(we_i), .dat_i(dat_i),
    .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .dat_o(dat_o),
    .busy_o(busy_o), .sm_start_o(sm_start_o), .sm_we_o(sm_we_o),
    .sm_dat_o(sm_dat_o), .sm_dat_i(sm_dat_i), .sm_dvalid_i(sm_dvalid_i),
    .sm_ready_i(sm_ready_i), .state_o(state_o)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  // Accepted commands: {we, dat}
  logic [8:0]  exp_cmd_q[$];
  // Completions: {is_timeout, gnt, done, err, dat_o}
  logic [13:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [13:0] mk(input logic to, input logic [1:0] g, input logic [1:0] d,
                                      input logic e, input logic [7:0] dt);
    return {to, g, d, e, dt};
  endfunction

  // ---------------- emmc_sm model ----------------
  // mode 0: normal (ready low for model_lat cycles, optional dvalid pulses)
  // mode 1: never drops ready after accept
  // mode 2: drops ready and holds it low until model_release
  int         model_mode    = 0;
  int         model_lat     = 2;
  int         model_dv      = 1;
  logic [7:0] model_rd1     = 8'h00;
  logic [7:0] model_rd2     = 8'h00;
  bit         model_release = 1'b0;
  int         accept_cyc    = 0;
  logic       acc_we;

  initial begin
    sm_ready_i  = 1'b1;
    sm_dvalid_i = 1'b0;
    sm_dat_i    = '0;
    forever begin
      @(negedge clk_i);
      if (!arst_i && sm_start_o && sm_ready_i) begin
        if (exp_cmd_q.size() == 0) chk("unexpected_start", {sm_we_o, sm_dat_o}, 32'h1ff_ffff);
        else chk("cmd", {sm_we_o, sm_dat_o}, exp_cmd_q.pop_front());
        acc_we     = sm_we_o;
        accept_cyc = cyc + 1;
        @(negedge clk_i);
        if (model_mode == 2) begin
          sm_ready_i = 1'b0;
          while (!model_release) @(negedge clk_i);
          sm_ready_i = 1'b1;
        end else if (model_mode == 0) begin
          sm_ready_i = 1'b0;
          repeat (model_lat) @(negedge clk_i);
          if (!acc_we && model_dv > 0) begin
            sm_dvalid_i = 1'b1;
            sm_dat_i    = model_rd1;
            @(negedge clk_i);
            if (model_dv > 1) begin
              sm_dat_i = model_rd2;
              @(negedge clk_i);
            end
            sm_dvalid_i = 1'b0;
            sm_dat_i    = 8'($urandom_range(0, 255));
          end
          sm_ready_i = 1'b1;
        end
      end
    end
  end

  // ---------------- output monitor ----------------
  logic [13:0] rec;
  initial begin
    forever begin
      @(negedge clk_i);
      chk("gnt_onehot0", 32'($onehot0(gnt_o)), 32'd1);
      if (done_o == '0) begin
        chk("err_without_done", err_o, 0);
      end else if (exp_q.size() == 0) begin
        chk("unexpected_done", done_o, 0);
      end else begin
        rec = exp_q.pop_front();
        chk("done_rec", {gnt_o, done_o, err_o, dat_o}, rec[12:0]);
        if (rec[13]) chk("timeout_latency", cyc - accept_cyc, TO);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Hold req until n done pulses were seen, then drop it right away so the
  // next IDLE cycle does not re-grant.
  task automatic run(input logic [1:0] req, input logic [1:0] we, input logic [7:0] d0,
                     input logic [7:0] d1, input int n);
    int seen   = 0;
    int budget = 0;
    we_i  = we;
    dat_i = {d1, d0};
    req_i = req;
    while (seen < n && budget < 400) begin
      @(posedge clk_i); #1;
      budget++;
      if (done_o != '0) seen++;
    end
    req_i = '0;
    chk("txn_count", seen, n);
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] last_rd;
    logic [7:0] d0, d1, d;
    logic [1:0] m;
    logic       w;
    logic       e;
    int         k;
    int         budget;

    req_i = '0; we_i = '0; dat_i = '0; arst_i = 1'b0;
    #1 arst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_outs", {gnt_o, done_o, err_o, dat_o, busy_o, sm_start_o, sm_we_o, sm_dat_o, state_o}, 0);
    @(negedge clk_i) arst_i = 1'b0;
    tick();
    last_rd = 8'h00;

    // single write from requester 0
    model_mode = 0; model_lat = 3;
    exp_cmd_q.push_back({1'b1, 8'h55});
    exp_q.push_back(mk(1'b0, 2'b01, 2'b01, 1'b0, last_rd));
    run(2'b01, 2'b01, 8'h55, 8'h00, 1);
    tick();

    // read from requester 1 with one dvalid
    model_dv = 1; model_rd1 = 8'hAA;
    exp_cmd_q.push_back({1'b0, 8'h12});
    last_rd = 8'hAA;
    exp_q.push_back(mk(1'b0, 2'b10, 2'b10, 1'b0, last_rd));
    run(2'b10, 2'b00, 8'h00, 8'h12, 1);
    tick();

    // fairness: both requesting continuously
    d0 = 8'($urandom_range(0, 255));
    d1 = 8'($urandom_range(0, 255));
    for (int i = 0; i < 2; i++) begin
      exp_cmd_q.push_back({1'b1, d0});
      exp_q.push_back(mk(1'b0, 2'b01, 2'b01, 1'b0, last_rd));
      exp_cmd_q.push_back({1'b1, d1});
      exp_q.push_back(mk(1'b0, 2'b10, 2'b10, 1'b0, last_rd));
    end
    run(2'b11, 2'b11, d0, d1, 4);
    tick();

    // read with two dvalid pulses: the last byte is kept
    model_dv = 2; model_rd1 = 8'h3C; model_rd2 = 8'hC3;
    exp_cmd_q.push_back({1'b0, 8'h77});
    last_rd = 8'hC3;
    exp_q.push_back(mk(1'b0, 2'b01, 2'b01, 1'b0, last_rd));
    run(2'b01, 2'b00, 8'h77, 8'h00, 1);
    tick();

    // read without dvalid: error, dat_o unchanged
    model_dv = 0;
    exp_cmd_q.push_back({1'b0, 8'h99});
    exp_q.push_back(mk(1'b0, 2'b10, 2'b10, 1'b1, last_rd));
    run(2'b10, 2'b00, 8'h00, 8'h99, 1);
    tick();

    // timeout, ready never drops after accept
    model_mode = 1;
    exp_cmd_q.push_back({1'b1, 8'hA5});
    exp_q.push_back(mk(1'b1, 2'b00, 2'b01, 1'b1, last_rd));
    run(2'b01, 2'b01, 8'hA5, 8'h00, 1);
    tick();
    chk("drain_exit_ready_high", busy_o, 0);
    tick();

    // timeout, ready held low: stays draining until ready returns
    model_mode = 2; model_release = 1'b0;
    exp_cmd_q.push_back({1'b0, 8'h5A});
    exp_q.push_back(mk(1'b1, 2'b00, 2'b10, 1'b1, last_rd));
    run(2'b10, 2'b00, 8'h00, 8'h5A, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("drain_hold", {busy_o, sm_start_o, gnt_o}, 4'b1000);
    end
    model_release = 1'b1;
    budget = 0;
    while (busy_o && budget < 20) begin
      tick();
      budget++;
    end
    chk("drain_release", busy_o, 0);
    model_mode = 0;
    model_release = 1'b0;
    tick();

    // random single-requester traffic
    for (int i = 0; i < 8; i++) begin
      k = $urandom_range(0, 1);
      m = 2'b01 << k;
      w = 1'($urandom_range(0, 1));
      d = 8'($urandom_range(0, 255));
      model_lat = $urandom_range(1, 6);
      model_dv  = $urandom_range(0, 2);
      model_rd1 = 8'($urandom_range(0, 255));
      model_rd2 = 8'($urandom_range(0, 255));
      e = !w && (model_dv == 0);
      if (!w && model_dv == 1) last_rd = model_rd1;
      if (!w && model_dv == 2) last_rd = model_rd2;
      exp_cmd_q.push_back({w, d});
      exp_q.push_back(mk(1'b0, m, m, e, last_rd));
      run(m, w ? m : 2'b00, (k == 0) ? d : 8'hFF, (k == 1) ? d : 8'hFF, 1);
      tick();
    end

    // leave the round-robin pointer at requester 1
    model_lat = 2;
    exp_cmd_q.push_back({1'b1, 8'h11});
    exp_q.push_back(mk(1'b0, 2'b01, 2'b01, 1'b0, last_rd));
    run(2'b01, 2'b01, 8'h11, 8'h00, 1);
    tick();

    // asynchronous reset in the middle of a read
    model_lat = 10; model_dv = 1; model_rd1 = 8'hEE;
    exp_cmd_q.push_back({1'b0, 8'h42});
    we_i = 2'b00; dat_i = {8'h00, 8'h42}; req_i = 2'b01;
    budget = 0;
    while (!(busy_o && !sm_ready_i) && budget < 30) begin
      tick();
      budget++;
    end
    chk("reach_busy", {busy_o, sm_ready_i}, 2'b10);
    #3 arst_i = 1'b1;
    #1;
    chk("arst_outs", {gnt_o, done_o, err_o, dat_o, busy_o, sm_start_o, sm_we_o, sm_dat_o, state_o}, 0);
    req_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) arst_i = 1'b0;
    budget = 0;
    while (!sm_ready_i && budget < 40) begin
      tick();
      budget++;
    end
    chk("model_idle_after_reset", sm_ready_i, 1);
    last_rd = 8'h00;
    model_lat = 3;
    d0 = 8'($urandom_range(0, 255));
    d1 = 8'($urandom_range(0, 255));
    exp_cmd_q.push_back({1'b1, d0});
    exp_q.push_back(mk(1'b0, 2'b01, 2'b01, 1'b0, last_rd));
    exp_cmd_q.push_back({1'b1, d1});
    exp_q.push_back(mk(1'b0, 2'b10, 2'b10, 1'b0, last_rd));
    tick();
    run(2'b11, 2'b11, d0, d1, 2);

    repeat (4) tick();
    chk("cmd_q_empty", exp_cmd_q.size(), 0);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
